// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared CPU debug-bus encodings and trace record constants
package cpu_dbg_pkg;
   localparam logic [3:0] ST_FETCH = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [7:0] TRACE_MAGIC = 8'hC5;
   localparam int REC_W = 80;
   typedef enum logic [1:0] {SEL_HDR, SEL_PC, SEL_INST} word_sel_e;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous show-ahead FIFO; a push while full is taken only alongside a pop
module trace_fifo #(
   parameter int W = 80,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rptr];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         wptr <= wptr + AW'(do_push);
         rptr <= rptr + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/dbg_trace_capture.sv
// dbg_trace_capture: captures one trace record per CPU instruction and streams it as 3 words
import cpu_dbg_pkg::*;
module dbg_trace_capture #(
   parameter int DEPTH = 16,
   parameter logic [3:0] CAP_STATE = ST_DECODE
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trace_en,
   input  logic [3:0]               dbg_state,
   input  logic [31:0]              dbg_pc,
   input  logic [31:0]              dbg_inst,
   output logic                     tr_valid,
   output logic [31:0]              tr_data,
   output logic                     tr_last,
   input  logic                     tr_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [15:0]              drop_count
);
   logic [3:0] prev_state;
   logic [15:0] seq;
   word_sel_e sel, sel_nxt;
   logic cap, hs, pop, drop, full, empty;
   logic [REC_W-1:0] head;
   assign cap = trace_en && dbg_state == CAP_STATE && prev_state != CAP_STATE;
   assign hs = tr_valid && tr_ready;
   assign pop = hs && sel == SEL_INST;
   assign drop = cap && full && !pop;
   assign tr_valid = !empty;
   trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(cap),
      .pop(pop),
      .din({seq, dbg_pc, dbg_inst}),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(fifo_count)
   );
   // seq advances on every event, dropped or not, so gaps in the stream reveal losses
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         prev_state <= 4'hF;
         seq <= '0;
         drop_count <= '0;
         overflow <= 1'b0;
         sel <= SEL_HDR;
      end else begin
         prev_state <= dbg_state;
         seq <= seq + 16'(cap);
         drop_count <= drop_count + 16'(drop && drop_count != 16'hFFFF);
         overflow <= overflow || drop;
         sel <= sel_nxt;
      end
   always_comb begin
      sel_nxt = !hs ? sel : sel == SEL_HDR ? SEL_PC : sel == SEL_PC ? SEL_INST : SEL_HDR;
      tr_data = !tr_valid ? 32'h0 :
                sel == SEL_HDR ? {TRACE_MAGIC, 8'h00, head[79:64]} :
                sel == SEL_PC ? head[63:32] : head[31:0];
      tr_last = tr_valid && sel == SEL_INST;
   end
endmodule

// File: tb/tb_dbg_trace_capture.sv
// tb_dbg_trace_capture: directed self-checking bench for dbg_trace_capture
module tb_dbg_trace_capture;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic trace_en = 1'b0;
   logic tr_ready = 1'b0;
   logic [3:0] dbg_state = 4'd0;
   logic [31:0] dbg_pc = '0;
   logic [31:0] dbg_inst = '0;
   logic tr_valid, tr_last, overflow;
   logic [31:0] tr_data;
   logic [4:0] fifo_count;
   logic [15:0] drop_count;
   int checks = 0;
   int errors = 0;

   dbg_trace_capture #(.DEPTH(16), .CAP_STATE(4'd1)) dut (
      .clk(clk),
      .reset(reset),
      .trace_en(trace_en),
      .dbg_state(dbg_state),
      .dbg_pc(dbg_pc),
      .dbg_inst(dbg_inst),
      .tr_valid(tr_valid),
      .tr_data(tr_data),
      .tr_last(tr_last),
      .tr_ready(tr_ready),
      .fifo_count(fifo_count),
      .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
   endtask

   task automatic ev(input logic [31:0] pc, input logic [31:0] inst);
      dbg_state = 4'd1; dbg_pc = pc; dbg_inst = inst;
      tick;
      dbg_state = 4'd2;
      tick;
      dbg_state = 4'd0;
      tick;
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", tr_valid); end
      checks++; if (tr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", tr_data); end
      checks++; if (tr_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", tr_last); end
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
   endtask

   task automatic test_single;
      trace_en = 1'b1; tr_ready = 1'b1; dbg_state = 4'd0;
      tick;
      dbg_state = 4'd1; dbg_pc = 32'h0000_0004; dbg_inst = 32'h2008_0005;
      tick;
      checks++; if (tr_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", tr_valid); end
      checks++; if (tr_data !== 32'hC500_0000 || tr_last !== 1'b0) begin errors++; $display("FAIL single_w0 got %h/%b exp c5000000/0", tr_data, tr_last); end
      dbg_state = 4'd2;
      tick;
      checks++; if (tr_data !== 32'h0000_0004 || tr_last !== 1'b0) begin errors++; $display("FAIL single_w1 got %h/%b exp 00000004/0", tr_data, tr_last); end
      tick;
      checks++; if (tr_data !== 32'h2008_0005 || tr_last !== 1'b1) begin errors++; $display("FAIL single_w2 got %h/%b exp 20080005/1", tr_data, tr_last); end
      dbg_state = 4'd0;
      tick;
      checks++; if (fifo_count !== 5'd0 || tr_valid !== 1'b0) begin errors++; $display("FAIL single_empty got count %0d valid %b exp 0/0", fifo_count, tr_valid); end
   endtask

   task automatic test_held;
      do_reset;
      trace_en = 1'b1; tr_ready = 1'b0; dbg_state = 4'd0;
      tick;
      dbg_state = 4'd1; dbg_pc = 32'h0000_0010; dbg_inst = 32'h0000_0011;
      repeat (5) tick;
      dbg_state = 4'd2;
      checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL held_count got %0d exp 1", fifo_count); end
      checks++; if (tr_data !== 32'hC500_0000) begin errors++; $display("FAIL held_hdr got %h exp c5000000", tr_data); end
      tr_ready = 1'b1;
      repeat (3) tick;
      dbg_state = 4'd0;
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL held_drain got %0d exp 0", fifo_count); end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_w [9] = '{32'hC500_0000, 32'h0000_0100, 32'hDEAD_0000,
                                 32'hC500_0001, 32'h0000_0104, 32'hDEAD_0001,
                                 32'hC500_0002, 32'h0000_0108, 32'hDEAD_0002};
      do_reset;
      trace_en = 1'b1; tr_ready = 1'b0;
      for (int i = 0; i < 3; i++) ev(32'h100 + 32'(4 * i), 32'hDEAD_0000 + 32'(i));
      checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL bp_count got %0d exp 3", fifo_count); end
      checks++; if (tr_data !== 32'hC500_0000) begin errors++; $display("FAIL bp_hdr got %h exp c5000000", tr_data); end
      repeat (2) tick;
      checks++; if (tr_data !== 32'hC500_0000 || tr_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got %h/%b exp c5000000/1", tr_data, tr_valid); end
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (tr_data !== exp_w[k] || tr_last !== (k % 3 == 2)) begin
            errors++; $display("FAIL bp_word%0d got %h/%b exp %h/%b", k, tr_data, tr_last, exp_w[k], k % 3 == 2);
         end
         tr_ready = 1'b1;
         tick;
         tr_ready = 1'b0;
         repeat (2) tick;
      end
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL bp_empty got %0d exp 0", fifo_count); end
   endtask

   task automatic test_trace_en;
      do_reset;
      trace_en = 1'b0; tr_ready = 1'b0;
      ev(32'h200, 32'h201);
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL en_off_count got %0d exp 0", fifo_count); end
      trace_en = 1'b1;
      ev(32'h300, 32'h301);
      checks++; if (tr_data !== 32'hC500_0000) begin errors++; $display("FAIL en_seq got %h exp c5000000", tr_data); end
      trace_en = 1'b0; tr_ready = 1'b1;
      tick;
      checks++; if (tr_data !== 32'h0000_0300) begin errors++; $display("FAIL en_drain_pc got %h exp 00000300", tr_data); end
      repeat (2) tick;
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL en_drain got %0d exp 0", fifo_count); end
      trace_en = 1'b1; tr_ready = 1'b0;
   endtask

   task automatic test_overflow;
      do_reset;
      trace_en = 1'b1; tr_ready = 1'b0;
      for (int i = 0; i < 18; i++) ev(32'(4 * i), 32'(i));
      checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", fifo_count); end
      checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      tr_ready = 1'b1;
      for (int r = 0; r < 16; r++) begin
         checks++;
         if (tr_data !== {8'hC5, 8'h00, 16'(r)}) begin errors++; $display("FAIL ovf_seq%0d got %h exp %h", r, tr_data, {8'hC5, 8'h00, 16'(r)}); end
         repeat (3) tick;
      end
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", fifo_count); end
      tr_ready = 1'b0;
      ev(32'h500, 32'h501);
      checks++; if (tr_data !== 32'hC500_0012) begin errors++; $display("FAIL ovf_next_seq got %h exp c5000012", tr_data); end
      tr_ready = 1'b1;
      repeat (3) tick;
      tr_ready = 1'b0;
   endtask

   task automatic test_full_pop;
      do_reset;
      trace_en = 1'b1; tr_ready = 1'b0;
      for (int i = 0; i < 16; i++) ev(32'(4 * i), 32'(i));
      checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fp_full got %0d exp 16", fifo_count); end
      tr_ready = 1'b1;
      repeat (2) tick;
      checks++; if (tr_last !== 1'b1) begin errors++; $display("FAIL fp_inst_sel got %b exp 1", tr_last); end
      dbg_state = 4'd1; dbg_pc = 32'h0000_0F00; dbg_inst = 32'h0000_0F01;
      tick;
      dbg_state = 4'd0;
      checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fp_count got %0d exp 16", fifo_count); end
      checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fp_drop got %0d/%b exp 0/0", drop_count, overflow); end
      checks++; if (tr_data !== 32'hC500_0001) begin errors++; $display("FAIL fp_head got %h exp c5000001", tr_data); end
      repeat (45) tick;
      checks++; if (tr_data !== 32'hC500_0010) begin errors++; $display("FAIL fp_last_hdr got %h exp c5000010", tr_data); end
      tick;
      checks++; if (tr_data !== 32'h0000_0F00) begin errors++; $display("FAIL fp_last_pc got %h exp 00000f00", tr_data); end
      tick;
      checks++; if (tr_data !== 32'h0000_0F01 || tr_last !== 1'b1) begin errors++; $display("FAIL fp_last_inst got %h/%b exp 00000f01/1", tr_data, tr_last); end
      tick;
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL fp_empty got %0d exp 0", fifo_count); end
      tr_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      ev(32'h40, 32'h41);
      checks++; if (tr_data !== 32'hC500_0011) begin errors++; $display("FAIL rm_hdr got %h exp c5000011", tr_data); end
      tr_ready = 1'b1;
      tick;
      tr_ready = 1'b0;
      checks++; if (tr_data !== 32'h0000_0040) begin errors++; $display("FAIL rm_pc got %h exp 00000040", tr_data); end
      reset = 1'b1;
      #1;
      checks++; if (tr_valid !== 1'b0 || tr_data !== 32'h0 || tr_last !== 1'b0) begin errors++; $display("FAIL rm_async got %b/%h/%b exp 0/00000000/0", tr_valid, tr_data, tr_last); end
      checks++; if (fifo_count !== 5'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rm_state got %0d/%0d/%b exp 0/0/0", fifo_count, drop_count, overflow); end
      tick;
      reset = 1'b0;
      tick;
      ev(32'h80, 32'h81);
      checks++; if (tr_data !== 32'hC500_0000 || fifo_count !== 5'd1) begin errors++; $display("FAIL rm_restart got %h/%0d exp c5000000/1", tr_data, fifo_count); end
      tr_ready = 1'b1;
      repeat (2) tick;
      checks++; if (tr_data !== 32'h0000_0081 || tr_last !== 1'b1) begin errors++; $display("FAIL rm_inst got %h/%b exp 00000081/1", tr_data, tr_last); end
      tick;
      checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rm_empty got %0d exp 0", fifo_count); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_held;
      test_backpressure;
      test_trace_en;
      test_overflow;
      test_full_pop;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
